// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// One quotient bit per clock, valid/ready handshake on both sides, overflow and divide-by-zero flagged up front.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;

  // One restoring iteration; the partial remainder stays below the divisor,
  // so only the shifted value needs the extra bit.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] q_n;
    sh  = {r, q[WIDTH-1]};
    q_n = q << 1;
    r_n = sh[WIDTH-1:0];
    if (sh >= {1'b0, d}) begin
      r_n    = sh[WIDTH-1:0] - d;
      q_n[0] = 1'b1;
    end
    return {r_n, q_n};
  endfunction

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dsr_d = divisor;
          cnt_d = '0;
          if (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            quo_d   = '1;
            rem_d   = '0;
            dz_d    = (divisor == '0);
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = dividend[2*WIDTH-1:WIDTH];
            quo_d   = dividend[WIDTH-1:0];
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        {rem_d, quo_d} = div_step(rem_q, quo_q, dsr_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: driver pushes expected results computed with
// plain integer division, a monitor pops and compares on every presented output.
module tb_seq_restoring_divider;

  typedef struct {
    int q;
    int r;
    int dz;
    int ov;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   seen = 0;
  exp_t sb[$];

  seq_restoring_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready changes just after the rising edge so the monitor sees a settled value
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int dd, input int dv);
    exp_t e;
    e.acc = 0;
    if (dv == 0) begin
      e.q = 255; e.r = 0; e.dz = 1; e.ov = 1;
    end else if (dd / dv > 255) begin
      e.q = 255; e.r = 0; e.dz = 0; e.ov = 1;
    end else begin
      e.q = dd / dv; e.r = dd % dv; e.dz = 0; e.ov = 0;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input int dd, input int dv);
    exp_t e;
    dividend = 16'(dd);
    divisor  = 8'(dv);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e = model(dd, dv);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      sb.delete();
      seen = 0;
      continue;
    end
    if (!out_valid) begin
      if (seen) check("valid_dropped", 0, 1);
      seen = 0;
      continue;
    end
    if (sb.size() == 0) begin
      check("unexpected_out_valid", 1, 0);
      continue;
    end
    e = sb[0];
    if (!seen) begin
      check("latency", cyc - e.acc, (e.ov != 0) ? 1 : 9);
      seen = 1;
    end
    check("quotient", int'(quotient), e.q);
    check("remainder", int'(remainder), e.r);
    check("div_zero", int'(div_zero), e.dz);
    check("overflow", int'(overflow), e.ov);
    if (out_ready) begin
      void'(sb.pop_front());
      seen = 0;
    end
  end

  initial begin
    int dd, dv;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_flags", int'({div_zero, overflow}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send(16'h3021, 8'h6F);
    send(16'h03E8, 8'h07);
    send(16'hFE01, 8'hFF);
    send(16'hFF00, 8'hFF);
    send(16'h1234, 8'h00);
    send(16'h0000, 8'h35);
    send(16'h00FE, 8'h01);
    drain();

    // Backpressure: results held, in_ready low, extra in_valid ignored
    rdy_mode = 1;
    send(16'h2710, 8'h64);
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    dividend = 16'h0001;
    divisor  = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    send(16'h0064, 8'h0A);
    drain();

    // Reset in the middle of a calculation
    send(16'h03E8, 8'h07);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_quotient", int'(quotient), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(16'h00FF, 8'h10);
    drain();

    // Random sweep with random out_ready
    rdy_mode = 2;
    for (int n = 0; n < 8000; n++) begin
      dv = int'($urandom_range(0, 255));
      if (dv != 0 && ($urandom % 2) == 0)
        dd = int'($urandom_range(0, dv - 1)) * 256 + int'($urandom_range(0, 255));
      else
        dd = int'($urandom & 32'hFFFF);
      send(dd, dv);
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
